// File: rtl/alu_control_hilo_if.sv
// ALU control bundle between decode/datapath and the ALU-control/HI-LO block.
// The master side is the issuer that produces the ALU code and owns HI/LO.
interface alu_control_hilo_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        aluop;
    logic [5:0]        funct;
    logic              start;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic [2:0]        control;
    logic [1:0]        res_sel;
    logic [DATA_W-1:0] hilo_out;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;

    modport master (
        input  aluop, funct, start, dataA, dataB,
        output control, res_sel, hilo_out, hi, lo, busy, done
    );

    modport slave (
        output aluop, funct, start, dataA, dataB,
        input  control, res_sel, hilo_out, hi, lo, busy, done
    );
endinterface

// File: rtl/alu_control_hilo.sv
// ALU control decode plus HI/LO register pair with a sequential shift-add multu engine.
// Decode is purely combinational; multu takes DATA_W cycles with busy high throughout.
module alu_control_hilo #(
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    alu_control_hilo_if.master bus
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] product_nxt;
    logic [DATA_W:0]     step_sum;
    logic [CNT_W-1:0]    cnt;
    logic                launch;
    logic                last_iter;

    always_comb begin
        bus.control = 3'b010;
        bus.res_sel = 2'b00;
        case (bus.aluop)
            2'b01: bus.control = 3'b110;
            2'b10: begin
                case (bus.funct)
                    FN_ADD:  bus.control = 3'b010;
                    FN_SUB:  bus.control = 3'b110;
                    FN_AND:  bus.control = 3'b000;
                    FN_OR:   bus.control = 3'b001;
                    FN_SLT:  bus.control = 3'b111;
                    FN_SLL: begin
                        bus.control = 3'b100;
                        bus.res_sel = 2'b01;
                    end
                    FN_MFHI, FN_MFLO: bus.res_sel = 2'b10;
                    default: bus.control = 3'b010;
                endcase
            end
            default: bus.control = 3'b010;
        endcase
    end

    assign launch    = bus.start && (bus.aluop == 2'b10) && (bus.funct == FN_MULTU)
                       && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == MUL) && (cnt == CNT_W'(DATA_W - 1));

    // The multiplier shares the low half of the product register, so product[0]
    // is always the current multiplier bit and shifts out as product bits shift in.
    assign step_sum    = {1'b0, product[2*DATA_W-1:DATA_W]} + (product[0] ? {1'b0, mcand} : '0);
    assign product_nxt = {step_sum, product[DATA_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = MUL;
            MUL:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = launch ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO only change on the final iteration, so a partial product never leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            product <= '0;
            cnt     <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else if (launch) begin
            mcand   <= bus.dataA;
            product <= {{DATA_W{1'b0}}, bus.dataB};
            cnt     <= '0;
        end else if (state == MUL) begin
            product <= product_nxt;
            cnt     <= cnt + CNT_W'(1);
            if (last_iter) begin
                hi_reg <= product_nxt[2*DATA_W-1:DATA_W];
                lo_reg <= product_nxt[DATA_W-1:0];
            end
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.hilo_out = (bus.funct == FN_MFHI) ? hi_reg : lo_reg;
    assign bus.busy     = (state == MUL);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_alu_control_hilo.sv
// Self-checking bench: a cycle-level model (plain 64-bit multiply after a 32-cycle wait)
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_alu_control_hilo;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    bit   cmp_on = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_control_hilo_if #(.DATA_W(W)) bus ();

    alu_control_hilo #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] m_hi, m_lo, m_a, m_b;
    int           m_left;
    bit           m_done;
    logic         m_go;

    // Model: a multu takes W cycles from launch, then the exact product appears and done pulses.
    assign m_go = bus.start && (bus.aluop == 2'b10) && (bus.funct == 6'b011001) && (m_left == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) {m_hi, m_lo} <= {32'b0, m_a} * {32'b0, m_b};
        end else begin
            m_done <= 1'b0;
            if (m_go) begin
                m_a    <= bus.dataA;
                m_b    <= bus.dataB;
                m_left <= W;
            end
        end
    end

    function automatic logic [4:0] model_decode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b01) return {3'b110, 2'b00};
        if (op != 2'b10) return {3'b010, 2'b00};
        case (fn)
            6'b100000: return {3'b010, 2'b00};
            6'b100010: return {3'b110, 2'b00};
            6'b100100: return {3'b000, 2'b00};
            6'b100101: return {3'b001, 2'b00};
            6'b101010: return {3'b111, 2'b00};
            6'b000000: return {3'b100, 2'b01};
            6'b010000, 6'b010010: return {3'b010, 2'b10};
            default: return {3'b010, 2'b00};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            logic [4:0] d;
            d = model_decode(bus.aluop, bus.funct);
            checkOutput("cyc_control", 64'(bus.control), 64'(d[4:2]));
            checkOutput("cyc_res_sel", 64'(bus.res_sel), 64'(d[1:0]));
            checkOutput("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
            checkOutput("cyc_done", 64'(bus.done), 64'(m_done));
            checkOutput("cyc_hi", 64'(bus.hi), 64'(m_hi));
            checkOutput("cyc_lo", 64'(bus.lo), 64'(m_lo));
            checkOutput("cyc_hilo_out", 64'(bus.hilo_out),
                        64'((bus.funct == 6'b010000) ? m_hi : m_lo));
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic st,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        bus.aluop = op;
        bus.funct = fn;
        bus.start = st;
        bus.dataA = a;
        bus.dataB = b;
    endtask

    task automatic waitDone(input string name, output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: done never seen, got busy_cycles=%0d, required done within 40", name, busy_cycles);
        end
    endtask

    localparam logic [1:0] SW_OP  [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                           2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    localparam logic [5:0] SW_FN  [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                           6'b101010, 6'b000000, 6'b100100, 6'b100101,
                                           6'b000000, 6'b010000, 6'b010010, 6'b111111};
    localparam logic [2:0] SW_CTL [12] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100,
                                           3'b010, 3'b110, 3'b010, 3'b010, 3'b010, 3'b010};
    localparam logic [1:0] SW_SEL [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                                           2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    initial begin
        int bc;
        rst       = 1'b1;
        bus.aluop = 2'b00;
        bus.funct = 6'b0;
        bus.start = 1'b0;
        bus.dataA = '0;
        bus.dataB = '0;
        @(posedge clk);
        #1;
        cmp_on = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(SW_OP[i], SW_FN[i], 1'b0, '0, '0);
            @(negedge clk);
            #1;
            checkOutput($sformatf("decode_ctl_%0d", i), 64'(bus.control), 64'(SW_CTL[i]));
            checkOutput($sformatf("decode_sel_%0d", i), 64'(bus.res_sel), 64'(SW_SEL[i]));
        end

        // 7 * 6
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'd7, 32'd6);
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        waitDone("mul7x6", bc);
        checkOutput("mul7x6_busy_cycles", 64'(bc), 64'd32);
        checkOutput("mul7x6_lo", 64'(bus.lo), 64'h2A);
        checkOutput("mul7x6_hi", 64'(bus.hi), 64'h0);
        checkOutput("mul7x6_mflo", 64'(bus.hilo_out), 64'h2A);
        checkOutput("mul7x6_sel", 64'(bus.res_sel), 64'h2);
        @(negedge clk);
        #1;
        checkOutput("mul7x6_done_pulse", 64'(bus.done), 64'd0);

        // all-ones squared
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(2'b10, F_MFHI, 1'b0, '0, '0);
        waitDone("mulmax", bc);
        checkOutput("mulmax_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        checkOutput("mulmax_lo", 64'(bus.lo), 64'h0000_0001);
        checkOutput("mulmax_mfhi", 64'(bus.hilo_out), 64'hFFFF_FFFE);

        // second multu while busy is ignored
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000);
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        repeat (9) applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'd3, 32'd3);
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        waitDone("ignored", bc);
        checkOutput("ignored_busy_cycles", 64'(bc), 64'd21);
        checkOutput("ignored_hi", 64'(bus.hi), 64'h1);
        checkOutput("ignored_lo", 64'(bus.lo), 64'h0);

        // back-to-back: relaunch during the done cycle
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'd2, 32'd9);
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        waitDone("b2b_first", bc);
        checkOutput("b2b_first_lo", 64'(bus.lo), 64'd18);
        bus.start = 1'b1;
        bus.funct = F_MULTU;
        bus.dataA = 32'd3;
        bus.dataB = 32'd5;
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        waitDone("b2b_second", bc);
        checkOutput("b2b_busy_cycles", 64'(bc), 64'd32);
        checkOutput("b2b_lo", 64'(bus.lo), 64'hF);
        checkOutput("b2b_hi", 64'(bus.hi), 64'h0);

        // reset during a multiply
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'h1234_0000, 32'h0001_0000);
        applyStimulus(2'b10, F_MFHI, 1'b0, '0, '0);
        waitDone("pre_rst", bc);
        checkOutput("pre_rst_hi", 64'(bus.hi), 64'h1234);
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'd5, 32'd7);
        applyStimulus(2'b10, F_MFHI, 1'b0, '0, '0);
        repeat (14) applyStimulus(2'b10, F_MFHI, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_mid_hi", 64'(bus.hi), 64'd0);
        checkOutput("rst_mid_lo", 64'(bus.lo), 64'd0);
        checkOutput("rst_mid_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            checkOutput("rst_no_done", 64'(bus.done), 64'd0);
        end
        applyStimulus(2'b10, F_MULTU, 1'b1, 32'd2, 32'd2);
        applyStimulus(2'b10, F_MFLO, 1'b0, '0, '0);
        waitDone("post_rst", bc);
        checkOutput("post_rst_lo", 64'(bus.lo), 64'd4);
        checkOutput("post_rst_mflo", 64'(bus.hilo_out), 64'd4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_control_hilo.md
Name: alu_control_hilo

Overview:
- Issuer side of the ALU control interface: decodes the main-control ALUop and the R-type funct field into the 3-bit ALU control code and the datapath result-select.
- Owns the HI/LO register pair. Executes unsigned multiply (multu) sequentially with a 32-iteration shift-add engine.
- Sits between the instruction decode stage and the ALU/shifter.
- The datapath stalls on busy and reads HI/LO through the result mux.

Parameters:
- DATA_W, 32, operand width and width of HI and of LO. The product is 2*DATA_W bits. The iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- aluop  in  2  main-control op: 00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 reserved
- funct  in  6  R-type function field
- start  in  1  instruction valid this cycle; qualifies multu launch only
- dataA  in  DATA_W  multiplicand (rs)
- dataB  in  DATA_W  multiplier (rt)
- control  out  3  ALU code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL
- res_sel  out  2  result mux select: 00 ALU, 01 shifter, 10 HI/LO
- hilo_out  out  DATA_W  HI when funct=010000 (mfhi), otherwise LO
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: HI/LO just written by multu

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Decode (combinational, no latency):
  - aluop=00 -> control 010.
  - aluop=01 -> control 110.
  - aluop=11 -> control 010, res_sel 00.
  - aluop=10, by funct: 100000 add -> 010; 100010 sub -> 110; 100100 and -> 000; 100101 or -> 001; 101010 slt -> 111; 000000 sll -> 100 with res_sel 01.
  - aluop=10, funct 010000 mfhi / 010010 mflo -> res_sel 10, control 010.
  - aluop=10, funct 011001 multu -> control 010, res_sel 00.
  - aluop=10, any other funct -> control 010, res_sel 00.
  - res_sel is 00 for all cases not listed above.
- Reset (asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0; internal product, multiplicand, multiplier and count cleared.
- FSM states: IDLE, MUL, DONE.
- Launch condition: start=1, aluop=10, funct=011001, state in IDLE or DONE.
  - IDLE -> MUL on launch. Latch mcand=dataA, mplier=dataB; product=0; cnt=0.
  - DONE -> MUL on launch (back-to-back multu is allowed). DONE -> IDLE otherwise.
- MUL, one iteration per clock:
  - If mplier[0]=1, product[2W-1:W-1] = product[2W-1:W] + mcand, a (W+1)-bit sum including the carry. Otherwise product[2W-1:W-1] = {1'b0, product[2W-1:W]}.
  - product[W-2:0] = product[W-1:1]; mplier = mplier>>1; cnt=cnt+1.
  - On the iteration with cnt=W-1: hi<=final product[2W-1:W], lo<=final product[W-1:0], state->DONE.
- Latency: launch at edge E0; HI/LO valid after edge E_W (E32 for W=32); done=1 during the cycle following E_W.
- busy=1 exactly while state=MUL (W cycles); done=1 exactly while state=DONE. busy and done are never both 1.
- start with multu while busy=1 is ignored: no relaunch, operands not re-latched. The stall guarantees this case does not occur; the block still must not corrupt state.
- hilo_out reads hi/lo registers directly. mfhi/mflo while busy returns the pre-multiply values; the caller stalls on busy.
- hi/lo hold their value until the next multu completes or rst. A partial product is never visible on hi/lo.
- rst asserted mid-MUL: immediate return to IDLE; hi/lo cleared; no done pulse.
- Multiply is unsigned and exact; the full 2W-bit product is kept, with no overflow.

Test Plan:
- Decode sweep: aluop=10 with funct 100000/100010/100100/100101/101010/000000 -> control 010/110/000/001/111/100; sll gives res_sel=01. aluop=00 -> 010. aluop=01 -> 110.
- multu 7*6: start at E0 -> busy=1 for 32 cycles; at E32 lo=0x0000002A, hi=0; done high one cycle; mflo gives hilo_out=0x2A with res_sel=10.
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mfhi returns 0xFFFFFFFE.
- Second multu start at cycle 10 of a running multiply (0x10000*0x10000) -> ignored; result hi=0x1, lo=0 at the original E32; busy never extends.
- Back-to-back: new multu (3*5) issued during the DONE cycle -> relaunch without an IDLE cycle; lo=0xF after 32 more edges.
- rst pulsed at cycle 15 of a multiply (prior hi=0x1234) -> busy=0, hi=lo=0 immediately; no done pulse; a subsequent multu 2*2 gives lo=4.
